// File: rtl/nes_pad_poller_pkg.sv
// Shared definitions for the NES Classic pad poller: controller command codes,
// programme step indices, report decode bit positions and the state encoding.
package nes_pad_poller_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  localparam logic [4:0] STEP_INIT      = 5'd0;
  localparam logic [4:0] STEP_PTR       = 5'd10;
  localparam logic [4:0] STEP_PTR_LAST  = 5'd13;
  localparam logic [4:0] STEP_READ      = 5'd14;
  localparam logic [4:0] STEP_READ_LAST = 5'd22;

  localparam int RPT_BYTES = 6;

  // Bit positions inside report bytes 4 and 5 (buttons are active low there)
  localparam int BIT_A     = 4;  // byte 5
  localparam int BIT_B     = 6;  // byte 5
  localparam int BIT_SEL   = 4;  // byte 4
  localparam int BIT_START = 2;  // byte 4
  localparam int BIT_UP    = 0;  // byte 5
  localparam int BIT_DOWN  = 6;  // byte 4
  localparam int BIT_LEFT  = 1;  // byte 5
  localparam int BIT_RIGHT = 7;  // byte 4

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       wack;
    logic       last;
  } step_t;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic step_t make_step(input logic [1:0] cmd, input logic [7:0] wdata,
                                      input logic wack, input logic last);
    step_t s;
    s.cmd   = cmd;
    s.wdata = wdata;
    s.wack  = wack;
    s.last  = last;
    return s;
  endfunction

  // Returns {present, buttons}; an all-0xFF report means no pad answered.
  function automatic logic [8:0] decode_report(input logic [RPT_BYTES-1:0][7:0] rx);
    logic [8:0] r;
    if (&rx) begin
      r = 9'h000;
    end else begin
      r = {1'b1,
           ~rx[5][BIT_A], ~rx[5][BIT_B], ~rx[4][BIT_SEL], ~rx[4][BIT_START],
           ~rx[5][BIT_UP], ~rx[4][BIT_DOWN], ~rx[5][BIT_LEFT], ~rx[4][BIT_RIGHT]};
    end
    return r;
  endfunction

endpackage

// File: rtl/nes_pad_poller_if.sv
// Command interface between the pad poller (master) and the byte-level I2C
// controller (slave).
interface nes_pad_poller_if;
  logic [1:0] cmd;
  logic       start;
  logic [7:0] wdata;
  logic       wack;
  logic       ready;
  logic [7:0] rdata;
  logic       rdata_valid;

  modport master (
    output cmd, start, wdata, wack,
    input  ready, rdata, rdata_valid
  );

  modport slave (
    input  cmd, start, wdata, wack,
    output ready, rdata, rdata_valid
  );
endinterface

// File: rtl/nes_pad_seq_rom.sv
// Step programme ROM: INIT (0-9), register-pointer write (10-13) and
// 6-byte report read (14-22).
module nes_pad_seq_rom
  import nes_pad_poller_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h52
) (
  input  logic [4:0] step,
  output step_t      entry
);

  localparam logic [7:0] ADDR_W = {DEV_ADDR, 1'b0};
  localparam logic [7:0] ADDR_R = {DEV_ADDR, 1'b1};

  // Step lookup; unused indices decode to a phase-final STOP
  always_comb begin
    entry = make_step(CMD_STOP, 8'h00, 1'b0, 1'b1);
    case (step)
      5'd0:    entry = make_step(CMD_START, 8'h00,  1'b0, 1'b0);
      5'd1:    entry = make_step(CMD_WRITE, ADDR_W, 1'b0, 1'b0);
      5'd2:    entry = make_step(CMD_WRITE, 8'hF0,  1'b0, 1'b0);
      5'd3:    entry = make_step(CMD_WRITE, 8'h55,  1'b0, 1'b0);
      5'd4:    entry = make_step(CMD_STOP,  8'h00,  1'b0, 1'b0);
      5'd5:    entry = make_step(CMD_START, 8'h00,  1'b0, 1'b0);
      5'd6:    entry = make_step(CMD_WRITE, ADDR_W, 1'b0, 1'b0);
      5'd7:    entry = make_step(CMD_WRITE, 8'hFB,  1'b0, 1'b0);
      5'd8:    entry = make_step(CMD_WRITE, 8'h00,  1'b0, 1'b0);
      5'd9:    entry = make_step(CMD_STOP,  8'h00,  1'b0, 1'b1);
      5'd10:   entry = make_step(CMD_START, 8'h00,  1'b0, 1'b0);
      5'd11:   entry = make_step(CMD_WRITE, ADDR_W, 1'b0, 1'b0);
      5'd12:   entry = make_step(CMD_WRITE, 8'h00,  1'b0, 1'b0);
      5'd13:   entry = make_step(CMD_STOP,  8'h00,  1'b0, 1'b1);
      5'd14:   entry = make_step(CMD_START, 8'h00,  1'b0, 1'b0);
      5'd15:   entry = make_step(CMD_WRITE, ADDR_R, 1'b0, 1'b0);
      5'd16,
      5'd17,
      5'd18,
      5'd19,
      5'd20:   entry = make_step(CMD_READ,  8'h00,  1'b0, 1'b0);
      5'd21:   entry = make_step(CMD_READ,  8'h00,  1'b1, 1'b0);
      5'd22:   entry = make_step(CMD_STOP,  8'h00,  1'b0, 1'b1);
      default: entry = make_step(CMD_STOP,  8'h00,  1'b0, 1'b1);
    endcase
  end

endmodule

// File: rtl/nes_pad_poller.sv
// Sequences the I2C controller to initialise an NES Classic pad and then poll
// its report, decoding it into an active-high 8-bit button vector.
module nes_pad_poller
  import nes_pad_poller_pkg::*;
#(
  parameter int         POLL_INTERVAL = 100000,
  parameter int         CONV_DELAY    = 500,
  parameter logic [6:0] DEV_ADDR      = 7'h52
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  nes_pad_poller_if.master    i2c,
  output logic [7:0]          buttons,
  output logic                buttons_valid,
  output logic                present,
  output logic                busy
);

  localparam int MAX_DELAY = (POLL_INTERVAL > CONV_DELAY) ? POLL_INTERVAL : CONV_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_INTERVAL);
  localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_DELAY);

  state_t                      state_q, state_d;
  logic [4:0]                  step_q, step_d;
  logic                        init_done_q, init_done_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  cmd_q, cmd_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic                        wack_q, wack_d;
  logic                        start_q, start_d;
  logic [RPT_BYTES-1:0][7:0]   rx_q, rx_d;
  logic [2:0]                  rd_idx_q, rd_idx_d;
  logic [7:0]                  buttons_q, buttons_d;
  logic                        valid_q, valid_d;
  logic                        present_q, present_d;
  logic                        busy_q, busy_d;
  logic [8:0]                  decode_s;
  step_t                       rom_s;
  logic                        rdata_valid_unused;

  nes_pad_seq_rom #(.DEV_ADDR(DEV_ADDR)) u_rom (
    .step  (step_q),
    .entry (rom_s)
  );

  assign decode_s           = decode_report(rx_q);
  assign rdata_valid_unused = i2c.rdata_valid;

  // Next-state and output computation for the step sequencer
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    wack_d      = wack_q;
    start_d     = 1'b0;
    rx_d        = rx_q;
    rd_idx_d    = rd_idx_q;
    buttons_d   = buttons_q;
    valid_d     = 1'b0;
    present_d   = present_q;

    case (state_q)
      S_WAIT: begin
        // enable only matters here, at a phase boundary
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (enable) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (i2c.ready) begin
          start_d = 1'b1;
          cmd_d   = rom_s.cmd;
          wdata_d = rom_s.wdata;
          wack_d  = rom_s.wack;
          state_d = S_BUSY;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_BUSY: begin
        if (!i2c.ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (i2c.ready) begin
          if (cmd_q == CMD_READ) begin
            rx_d[rd_idx_q] = i2c.rdata;
            rd_idx_d       = rd_idx_q + 3'd1;
          end else begin
            rd_idx_d = rd_idx_q;
          end
          if (rom_s.last) begin
            state_d = S_WAIT;
            if (!init_done_q) begin
              init_done_d = 1'b1;
              cnt_d       = '0;
              step_d      = STEP_PTR;
            end else if (step_q == STEP_PTR_LAST) begin
              cnt_d  = CONV_LOAD;
              step_d = STEP_READ;
            end else begin
              cnt_d     = POLL_LOAD;
              step_d    = STEP_PTR;
              rd_idx_d  = 3'd0;
              present_d = decode_s[8];
              buttons_d = decode_s[7:0];
              valid_d   = 1'b1;
            end
          end else begin
            state_d = S_ISSUE;
            step_d  = step_q + 5'd1;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_WAIT;
        step_d  = STEP_INIT;
      end
    endcase

    busy_d = (state_d != S_WAIT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      step_q      <= STEP_INIT;
      init_done_q <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= 2'd0;
      wdata_q     <= 8'h00;
      wack_q      <= 1'b0;
      start_q     <= 1'b0;
      rx_q        <= '0;
      rd_idx_q    <= 3'd0;
      buttons_q   <= 8'h00;
      valid_q     <= 1'b0;
      present_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      wack_q      <= wack_d;
      start_q     <= start_d;
      rx_q        <= rx_d;
      rd_idx_q    <= rd_idx_d;
      buttons_q   <= buttons_d;
      valid_q     <= valid_d;
      present_q   <= present_d;
      busy_q      <= busy_d;
    end
  end

  assign i2c.cmd       = cmd_q;
  assign i2c.start     = start_q;
  assign i2c.wdata     = wdata_q;
  assign i2c.wack      = wack_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign present       = present_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench for nes_pad_poller with a 4-cycle-busy I2C controller model.
module tb_nes_pad_poller;

  localparam int POLL = 150;
  localparam int CONV = 40;

  localparam logic [1:0] T_START = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_READ  = 2'd2;
  localparam logic [1:0] T_STOP  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       present;
  logic       busy;

  nes_pad_poller_if bus ();

  nes_pad_poller #(.POLL_INTERVAL(POLL), .CONV_DELAY(CONV), .DEV_ADDR(7'h52)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .i2c           (bus),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .present       (present),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          log_n;
  int          busy_cnt;
  int          rd_cnt;
  logic [1:0]  cur_cmd;
  logic [10:0] log_ent   [128];
  int          log_start [128];
  int          log_done  [128];
  logic [7:0]  resp      [6];
  int          valid_cnt = 0;
  int          valid_cyc = 0;
  int          bad_pulse = 0;
  int          bad_ready = 0;
  logic        prev_start = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Cycle counter, not reset
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: ready drops the cycle after start, rises 4 cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready       <= 1'b1;
      bus.rdata       <= 8'h00;
      bus.rdata_valid <= 1'b0;
      busy_cnt        <= 0;
      log_n           <= 0;
      rd_cnt          <= 0;
      cur_cmd         <= 2'd0;
    end else if (bus.start && bus.ready) begin
      log_ent[log_n]   <= {bus.cmd, bus.wdata, bus.wack};
      log_start[log_n] <= cyc;
      log_n            <= log_n + 1;
      cur_cmd          <= bus.cmd;
      bus.ready        <= 1'b0;
      bus.rdata_valid  <= 1'b0;
      busy_cnt         <= 4;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        bus.ready          <= 1'b1;
        log_done[log_n-1]  <= cyc + 1;
        if (cur_cmd == T_READ) begin
          bus.rdata       <= resp[rd_cnt % 6];
          bus.rdata_valid <= 1'b1;
          rd_cnt          <= rd_cnt + 1;
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.start && prev_start) bad_pulse <= bad_pulse + 1;
    if (bus.start && !bus.ready) bad_ready <= bad_ready + 1;
    prev_start <= bus.start;
    if (buttons_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [1:0] c, input logic [7:0] d, input logic k);
    return {c, d, k};
  endfunction

  // Expected {cmd, wdata, wack} for programme step s
  function automatic logic [10:0] exp_step(input int s);
    case (s)
      0, 5, 10, 14: return mk(T_START, 8'h00, 1'b0);
      1, 6, 11:     return mk(T_WRITE, 8'hA4, 1'b0);
      2:            return mk(T_WRITE, 8'hF0, 1'b0);
      3:            return mk(T_WRITE, 8'h55, 1'b0);
      7:            return mk(T_WRITE, 8'hFB, 1'b0);
      8, 12:        return mk(T_WRITE, 8'h00, 1'b0);
      15:           return mk(T_WRITE, 8'hA5, 1'b0);
      16, 17, 18, 19, 20: return mk(T_READ, 8'h00, 1'b0);
      21:           return mk(T_READ, 8'h00, 1'b1);
      default:      return mk(T_STOP, 8'h00, 1'b0);
    endcase
  endfunction

  function automatic int step_of(input int idx);
    return (idx < 10) ? idx : 10 + ((idx - 10) % 13);
  endfunction

  task automatic check_log(input int idx);
    check($sformatf("cmd[%0d]", idx), 32'(log_ent[idx]), 32'(exp_step(step_of(idx))));
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_n < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (log_n < n) check(tag, 32'(log_n), 32'(n));
  endtask

  task automatic wait_valid(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (valid_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (valid_cnt < n) check(tag, 32'(valid_cnt), 32'(n));
  endtask

  task automatic set_resp(input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] fill);
    for (int i = 0; i < 4; i++) resp[i] = fill;
    resp[4] = b4;
    resp[5] = b5;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    set_resp(8'h7F, 8'hEF, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd",     32'(bus.cmd),       32'd0);
    check("rst_start",   32'(bus.start),     32'd0);
    check("rst_wdata",   32'(bus.wdata),     32'd0);
    check("rst_wack",    32'(bus.wack),      32'd0);
    check("rst_buttons", 32'(buttons),       32'd0);
    check("rst_valid",   32'(buttons_valid), 32'd0);
    check("rst_present", 32'(present),       32'd0);
    check("rst_busy",    32'(busy),          32'd0);

    // INIT, PTR, first READ: A+Right
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1, 3000, "first_poll_timeout");
    for (int i = 0; i < 23; i++) check_log(i);
    check("buttons_ar", 32'(buttons), 32'h81);
    check("present_ar", 32'(present), 32'd1);
    check("valid_lat",  32'(valid_cyc), 32'(log_done[22] + 1));
    check("conv_gap",   32'((log_start[14] - log_done[13]) >= CONV), 32'd1);
    repeat (5) @(negedge clk);
    check("valid_once", 32'(valid_cnt), 32'd1);

    // Absent pad
    set_resp(8'hFF, 8'hFF, 8'hFF);
    wait_valid(2, 3000, "absent_poll_timeout");
    check("buttons_ff", 32'(buttons), 32'h00);
    check("present_ff", 32'(present), 32'd0);
    repeat (5) @(negedge clk);
    check("valid_ff_once", 32'(valid_cnt), 32'd2);

    // Drop enable during the third read: B+Start+Up
    set_resp(8'hFB, 8'hBE, 8'h12);
    wait_log(45, 3000, "third_read_timeout");
    enable = 1'b0;
    wait_valid(3, 3000, "disabled_poll_timeout");
    for (int i = 45; i < 49; i++) check_log(i);
    check("buttons_bsu", 32'(buttons), 32'h58);
    check("present_bsu", 32'(present), 32'd1);
    repeat (2 * POLL + 100) @(negedge clk);
    check("no_start_disabled", 32'(log_n), 32'd49);
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_log(51, 2000, "restart_timeout");
    check_log(49);
    check_log(50);
    check("poll_gap", 32'((log_start[49] - log_done[48]) >= POLL), 32'd1);

    // Reset in the middle of a READ phase, while start is high
    wait_log(56, 3000, "mid_read_timeout");
    for (int k = 0; k < 50 && !bus.start; k++) begin
      @(posedge clk);
      #1;
    end
    check("start_seen", 32'(bus.start), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_start",   32'(bus.start), 32'd0);
    check("arst_busy",    32'(busy),      32'd0);
    check("arst_buttons", 32'(buttons),   32'd0);
    check("arst_present", 32'(present),   32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_log(3, 500, "reinit_timeout");
    for (int i = 0; i < 3; i++) check_log(i);

    check("start_pulse_width", 32'(bad_pulse), 32'd0);
    check("start_while_ready", 32'(bad_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
